// File: rtl/run_controller_pkg.sv
// Shared controller state encoding and default widths for the run controller
// and the processor it sequences.
package run_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } run_state_e;

  localparam int DEF_IA_W  = 5;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_controller.sv
// Run/step/stop sequencer for a single-cycle processor: owns the PC register,
// gates commits and data-memory writes, and counts retired instructions.
//
// state  | meaning
// IDLE   | paused, waiting for a run or step request
// RUN    | committing one instruction per cycle until stop or HALT
// STEP   | committing exactly one instruction, then back to IDLE
// HALTED | HALT reached; PC parked on the HALT address until reset
module run_controller
  import run_controller_pkg::*;
#(
  parameter int IA_W  = DEF_IA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             runReq,
  input  logic             stepReq,
  input  logic             stopReq,
  input  logic [IA_W-1:0]  nextInstructionAddress,
  input  logic             halt,
  input  logic             memWrite,
  output logic [IA_W-1:0]  currentInstructionAddress,
  output logic             cpuEnable,
  output logic             memWriteEn,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retiredCount
);

  run_state_e      state_q;
  run_state_e      state_d;
  logic [IA_W-1:0] pc_q;

  // Reset forces the enable low in the same cycle so a reset mid-RUN cannot commit.
  assign cpuEnable  = !reset && ((state_q == RUN) || (state_q == STEP)) && !halt;
  assign memWriteEn = memWrite && cpuEnable;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (stopReq) begin
          state_d = IDLE;
        end else if (runReq) begin
          state_d = RUN;
        end else if (stepReq) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (stopReq) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        state_d = halt ? HALTED : IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cpuEnable) begin
        pc_q <= nextInstructionAddress;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_retired (
    .clk     (clk),
    .clr_i   (reset),
    .en_i    (cpuEnable),
    .count_o (retiredCount)
  );

  assign state                     = state_q;
  assign currentInstructionAddress = pc_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a per-cycle reference model checked at
// every falling edge, plus literal spot checks after key sequences.
module tb_run_controller;

  localparam int IA_W    = 5;
  localparam int CNT_W   = 8;
  localparam int PC_MOD  = 1 << IA_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             runReq = 1'b0;
  logic             stepReq = 1'b0;
  logic             stopReq = 1'b0;
  logic [IA_W-1:0]  nextInstructionAddress = '0;
  logic             halt = 1'b0;
  logic             memWrite = 1'b0;
  logic [IA_W-1:0]  currentInstructionAddress;
  logic             cpuEnable;
  logic             memWriteEn;
  logic [1:0]       state;
  logic [CNT_W-1:0] retiredCount;

  int n_vec = 0;
  int n_bad = 0;

  run_controller #(.IA_W(IA_W), .CNT_W(CNT_W)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .runReq                    (runReq),
    .stepReq                   (stepReq),
    .stopReq                   (stopReq),
    .nextInstructionAddress    (nextInstructionAddress),
    .halt                      (halt),
    .memWrite                  (memWrite),
    .currentInstructionAddress (currentInstructionAddress),
    .cpuEnable                 (cpuEnable),
    .memWriteEn                (memWriteEn),
    .state                     (state),
    .retiredCount              (retiredCount)
  );

  always #5 clk = ~clk;

  // Reference model: mode, PC and retired count as plain integers.
  int m_mode = 0, m_pc = 0, m_cnt = 0;
  int n_mode = 0, n_pc = 0, n_cnt = 0;
  bit m_valid = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit committing;
    committing = !reset && !halt && (m_mode == M_RUN || m_mode == M_STEP);
    if (m_valid) begin
      check("cpuEnable",  int'(cpuEnable), int'(committing));
      check("memWriteEn", int'(memWriteEn), int'(committing && memWrite));
      check("state",      int'(state), m_mode);
      check("pc",         int'(currentInstructionAddress), m_pc);
      check("retired",    int'(retiredCount), m_cnt);
    end
    n_mode = m_mode;
    n_pc   = m_pc;
    n_cnt  = m_cnt;
    if (reset) begin
      n_mode = M_IDLE;
      n_pc   = 0;
      n_cnt  = 0;
    end else begin
      if (committing) begin
        n_pc  = int'(nextInstructionAddress) % PC_MOD;
        n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
      if (m_mode == M_IDLE) begin
        if (stopReq)       n_mode = M_IDLE;
        else if (runReq)   n_mode = M_RUN;
        else if (stepReq)  n_mode = M_STEP;
      end else if (m_mode == M_RUN) begin
        if (halt)          n_mode = M_HALTED;
        else if (stopReq)  n_mode = M_IDLE;
      end else if (m_mode == M_STEP) begin
        n_mode = halt ? M_HALTED : M_IDLE;
      end
    end
  end

  always @(posedge clk) begin
    m_mode  <= n_mode;
    m_pc    <= n_pc;
    m_cnt   <= n_cnt;
    m_valid <= m_valid | reset;
  end

  // One clock of stimulus; pulses drop back to 0 on the next call.
  task automatic tick(input bit rs, input bit ru, input bit sr, input bit sp,
                      input int nia, input bit h, input bit mw);
    reset   = rs;
    runReq  = ru;
    stepReq = sr;
    stopReq = sp;
    nextInstructionAddress = IA_W'(nia);
    halt     = h;
    memWrite = mw;
    @(posedge clk);
    #1;
    reset = 0; runReq = 0; stepReq = 0; stopReq = 0; halt = 0; memWrite = 0;
  endtask

  task automatic lit_regs(input string nm, input int st, input int pc, input int cnt);
    check({nm, ".state"}, int'(state), st);
    check({nm, ".pc"}, int'(currentInstructionAddress), pc);
    check({nm, ".retired"}, int'(retiredCount), cnt);
  endtask

  initial begin
    // Reset state
    tick(1, 1, 1, 0, 7, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    lit_regs("reset", 0, 0, 0);
    check("reset.cpuEnable", int'(cpuEnable), 0);

    // Single step to address 1
    tick(0, 0, 1, 0, 1, 0, 0);
    check("step.state", int'(state), 2);
    check("step.cpuEnable", int'(cpuEnable), 1);
    tick(0, 0, 0, 0, 1, 0, 1);
    lit_regs("step_done", 0, 1, 1);
    tick(0, 0, 0, 0, 9, 0, 1);
    lit_regs("idle_hold", 0, 1, 1);

    // Run and stop together in IDLE: stop wins
    tick(0, 1, 0, 1, 9, 0, 1);
    lit_regs("run_stop", 0, 1, 1);
    // Run beats step; stop in RUN still commits that cycle
    tick(0, 1, 1, 0, 2, 0, 0);
    check("run_step.state", int'(state), 1);
    tick(0, 1, 0, 1, 2, 0, 1);
    lit_regs("run_then_stop", 0, 2, 2);

    // Run five instructions then HALT; later requests ignored
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, i + 1, 0, i[0]);
    tick(0, 0, 0, 0, 6, 1, 1);
    lit_regs("halted", 3, 5, 5);
    check("halted.cpuEnable", int'(cpuEnable), 0);
    tick(0, 1, 0, 0, 20, 0, 1);
    tick(0, 0, 1, 0, 20, 0, 1);
    tick(0, 0, 0, 1, 20, 0, 1);
    lit_regs("halted_absorb", 3, 5, 5);

    // HALT during a step, and HALT beating stop in RUN
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 4, 0, 0);
    tick(0, 0, 0, 0, 4, 1, 1);
    lit_regs("step_halt", 3, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 3, 1, 0);
    lit_regs("halt_over_stop", 3, 0, 0);

    // Requests during STEP are lost
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 8, 0, 0);
    lit_regs("step_drops_run", 0, 8, 1);

    // Long run: PC wraps via the next address, count saturates
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 0, 0, (i + 1) % 32, 0, i[1]);
      if (i == 31) check("wrap.pc", int'(currentInstructionAddress), 0);
    end
    lit_regs("saturate", 1, 12, 255);
    tick(0, 0, 0, 1, 13, 0, 0);
    lit_regs("saturate_stop", 0, 13, 255);

    // Reset mid-RUN with a pending write
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 1);
    lit_regs("pre_reset", 1, 1, 1);
    reset = 1; memWrite = 1; nextInstructionAddress = 5'd2;
    #1;
    check("reset_run.memWriteEn", int'(memWriteEn), 0);
    check("reset_run.cpuEnable", int'(cpuEnable), 0);
    tick(1, 0, 0, 0, 2, 0, 1);
    lit_regs("reset_run", 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter: IA_W, default 5, instruction-address width.
REQ-002 Parameter: CNT_W, default 8, retired-instruction counter width.
REQ-003 Ports, in order:
- clk  in  1  system clock; one clock.
- reset  in  1  synchronous, active-high reset.
- runReq  in  1  single-cycle pulse requesting free-running execution.
- stepReq  in  1  single-cycle pulse requesting exactly one instruction.
- stopReq  in  1  single-cycle pulse requesting a pause.
- nextInstructionAddress  in  IA_W  next PC computed by the processor.
- halt  in  1  current instruction is HALT (opcode decode).
- memWrite  in  1  processor data-memory write request.
- currentInstructionAddress  out  IA_W  PC register driven to instruction memory and processor.
- cpuEnable  out  1  commit enable for register file and PC this cycle.
- memWriteEn  out  1  gated data-memory write strobe.
- state  out  2  encoded controller state.
- retiredCount  out  CNT_W  instructions committed since reset.

Function
REQ-004 States: IDLE=0, RUN=1, STEP=2, HALTED=3; the state output SHALL equal the registered state.
REQ-005 cpuEnable SHALL be combinational: 1 iff (state==RUN or state==STEP) and halt==0.
REQ-006 memWriteEn SHALL equal memWrite AND cpuEnable; no memory write SHALL occur in IDLE, HALTED or on a HALT instruction.
REQ-007 On each rising clk with cpuEnable=1, PC SHALL load nextInstructionAddress; otherwise PC SHALL hold.
REQ-008 PC wrap-around (31 -> 0) SHALL come solely from nextInstructionAddress; the block SHALL NOT modify the address.
REQ-009 IDLE: stopReq -> stay IDLE; else runReq -> RUN; else stepReq -> STEP.
REQ-010 RUN: halt=1 -> HALTED (priority over stopReq); else stopReq -> IDLE; runReq and stepReq ignored.
REQ-011 STEP: lasts exactly one cycle; halt=1 -> HALTED; else -> IDLE; all requests ignored in that cycle.
REQ-012 HALTED: absorbing; runReq, stepReq and stopReq ignored; only reset exits.
REQ-013 Simultaneous requests in IDLE: stopReq > runReq > stepReq.
REQ-014 retiredCount SHALL increment by 1 on every clk where cpuEnable=1, saturating at 2^CNT_W-1 (no wrap).
REQ-015 The HALT instruction SHALL NOT be counted and SHALL NOT advance PC; in HALTED, PC stays at the HALT address.
REQ-016 Request pulses SHALL NOT be latched; a request not accepted in its cycle is lost.

Reset
REQ-017 reset=1 at a rising clk SHALL set state=IDLE, PC=0, retiredCount=0, regardless of current state or pending requests.
REQ-018 While reset=1, cpuEnable and memWriteEn SHALL be 0 (combinationally forced).
REQ-019 Reset mid-RUN SHALL suppress that cycle's commit and any memory write.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE/RUN/STEP/HALTED, 2 bits) and default widths IA_W=5, CNT_W=8; the mips module's 5-bit address and the top level SHALL use the same package.
REQ-021 One sub-module is natural: sat_counter (parameterised width, enable, synchronous clear) for retiredCount; PC register and FSM stay inline.
REQ-022 Top-level integration: cpuEnable SHALL gate the processor's register and PC writes; memWriteEn replaces memWrite at data memory.

Verification
REQ-023 Reset, then stepReq pulse with nextInstructionAddress=1 -> one cycle in STEP, cpuEnable=1 once, PC=1, retiredCount=1, state=IDLE.
REQ-024 runReq with nextInstructionAddress=PC+1 for 5 cycles, then halt=1 -> PC=5, retiredCount=5, state=HALTED, cpuEnable=0; later runReq/stepReq leave PC=5.
REQ-025 IDLE, runReq and stopReq in the same cycle -> state stays IDLE, PC unchanged, memWriteEn never 1.
REQ-026 RUN with PC=31, nextInstructionAddress=0 -> PC=0 next cycle; count continues; 300 committed cycles -> retiredCount=255.
REQ-027 RUN with memWrite=1 and reset asserted -> memWriteEn=0 that cycle; next cycle state=IDLE, PC=0, retiredCount=0.
